// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter for WB stage (A) and mul/div unit (B).
// Build option: define WB_ARB_RR_EN for round-robin between different-reg contenders.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              A_Valid,
  input  logic [REG_W-1:0]  A_Reg,
  input  logic [DATA_W-1:0] A_Data,
  output logic              A_Ready,
  input  logic              B_Valid,
  input  logic [REG_W-1:0]  B_Reg,
  input  logic [DATA_W-1:0] B_Data,
  output logic              B_Ready,
  output logic              RegWrite,
  output logic [REG_W-1:0]  WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              MuxSel,
  output logic              Stall
);

  logic              a_v_q, a_v_d;
  logic [REG_W-1:0]  a_reg_q, a_reg_d;
  logic [DATA_W-1:0] a_data_q, a_data_d;
  logic              b_v_q, b_v_d;
  logic [REG_W-1:0]  b_reg_q, b_reg_d;
  logic [DATA_W-1:0] b_data_q, b_data_d;
  logic              older_b_q, older_b_d;
  logic              rw_q, rw_d;
  logic [REG_W-1:0]  wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mux_q, mux_d;
`ifdef WB_ARB_RR_EN
  logic              last_q, last_d;
`endif

  logic pick_b;
  logic grant_a, grant_b;
  logic load_a, load_b;

  // Grant selection: age order on same reg, else build-selected policy.
  always_comb begin
    pick_b = 1'b0;
    if (a_reg_q == b_reg_q) begin
      pick_b = older_b_q;
    end else begin
`ifdef WB_ARB_RR_EN
      pick_b = ~last_q;
`else
      pick_b = 1'b0;
`endif
    end
    grant_a = a_v_q & ~(b_v_q & pick_b);
    grant_b = b_v_q & ~(a_v_q & ~pick_b);
  end

  assign A_Ready = ~a_v_q | grant_a;
  assign B_Ready = ~b_v_q | grant_b;
  assign Stall   = ~A_Ready;

  // A write to x0 is accepted but never stored.
  assign load_a = A_Valid & A_Ready & (A_Reg != '0);
  assign load_b = B_Valid & B_Ready & (B_Reg != '0);

  // Next state of slots, age bit and output register.
  always_comb begin
    a_v_d     = a_v_q;
    a_reg_d   = a_reg_q;
    a_data_d  = a_data_q;
    b_v_d     = b_v_q;
    b_reg_d   = b_reg_q;
    b_data_d  = b_data_q;
    older_b_d = older_b_q;
    rw_d      = 1'b0;
    wreg_d    = wreg_q;
    wdata_d   = wdata_q;
    mux_d     = mux_q;
`ifdef WB_ARB_RR_EN
    last_d    = last_q;
`endif

    if (grant_a) begin
      rw_d    = 1'b1;
      wreg_d  = a_reg_q;
      wdata_d = a_data_q;
      mux_d   = 1'b0;
      a_v_d   = 1'b0;
`ifdef WB_ARB_RR_EN
      last_d  = 1'b0;
`endif
    end else if (grant_b) begin
      rw_d    = 1'b1;
      wreg_d  = b_reg_q;
      wdata_d = b_data_q;
      mux_d   = 1'b1;
      b_v_d   = 1'b0;
`ifdef WB_ARB_RR_EN
      last_d  = 1'b1;
`endif
    end

    if (load_a) begin
      a_v_d    = 1'b1;
      a_reg_d  = A_Reg;
      a_data_d = A_Data;
    end
    if (load_b) begin
      b_v_d    = 1'b1;
      b_reg_d  = B_Reg;
      b_data_d = B_Data;
    end

    if (load_a && load_b) begin
      older_b_d = 1'b0;
    end else if (load_a && b_v_q && !grant_b) begin
      older_b_d = 1'b1;
    end else if (load_b && a_v_q && !grant_a) begin
      older_b_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      a_v_q     <= 1'b0;
      a_reg_q   <= '0;
      a_data_q  <= '0;
      b_v_q     <= 1'b0;
      b_reg_q   <= '0;
      b_data_q  <= '0;
      older_b_q <= 1'b0;
      rw_q      <= 1'b0;
      wreg_q    <= '0;
      wdata_q   <= '0;
      mux_q     <= 1'b0;
`ifdef WB_ARB_RR_EN
      last_q    <= 1'b1;
`endif
    end else begin
      a_v_q     <= a_v_d;
      a_reg_q   <= a_reg_d;
      a_data_q  <= a_data_d;
      b_v_q     <= b_v_d;
      b_reg_q   <= b_reg_d;
      b_data_q  <= b_data_d;
      older_b_q <= older_b_d;
      rw_q      <= rw_d;
      wreg_q    <= wreg_d;
      wdata_q   <= wdata_d;
      mux_q     <= mux_d;
`ifdef WB_ARB_RR_EN
      last_q    <= last_d;
`endif
    end
  end

  assign RegWrite  = rw_q;
  assign WriteReg  = wreg_q;
  assign WriteData = wdata_q;
  assign MuxSel    = mux_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter.
// Reference model orders same-register writes by load timestamp.
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int RW = 5;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          A_Valid, B_Valid;
  logic [RW-1:0] A_Reg, B_Reg;
  logic [DW-1:0] A_Data, B_Data;
  logic          A_Ready, B_Ready;
  logic          RegWrite, MuxSel, Stall;
  logic [RW-1:0] WriteReg;
  logic [DW-1:0] WriteData;

  int errors = 0;
  int checks = 0;

  regfile_wb_arbiter #(.DATA_W(DW), .REG_W(RW)) dut (
    .Clk(Clk), .Reset(Reset),
    .A_Valid(A_Valid), .A_Reg(A_Reg), .A_Data(A_Data), .A_Ready(A_Ready),
    .B_Valid(B_Valid), .B_Reg(B_Reg), .B_Data(B_Data), .B_Ready(B_Ready),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .MuxSel(MuxSel), .Stall(Stall)
  );

  always #5 Clk = ~Clk;

  // Reference model: pending writes tagged with the cycle they arrived.
  logic          ma_v, mb_v;
  logic [RW-1:0] ma_reg, mb_reg;
  logic [DW-1:0] ma_data, mb_data;
  int            ma_ts, mb_ts;
  int            cyc = 0;
  logic          m_rw, m_mux;
  logic [RW-1:0] m_wreg;
  logic [DW-1:0] m_wdata;
`ifdef WB_ARB_RR_EN
  logic          m_last;
`endif

  function automatic void mgrant(output logic ga, output logic gb);
    ga = 1'b0;
    gb = 1'b0;
    if (ma_v && mb_v) begin
      if (ma_reg == mb_reg) begin
        if (mb_ts < ma_ts) gb = 1'b1;
        else ga = 1'b1;
      end else begin
`ifdef WB_ARB_RR_EN
        if (m_last) ga = 1'b1;
        else gb = 1'b1;
`else
        ga = 1'b1;
`endif
      end
    end else begin
      ga = ma_v;
      gb = mb_v;
    end
  endfunction

  function automatic logic [2:0] mready();
    logic ga, gb, ra, rb;
    mgrant(ga, gb);
    ra = !ma_v || ga;
    rb = !mb_v || gb;
    return {ra, rb, !ra};
  endfunction

  function automatic logic [RW+DW+1:0] mout();
    return {m_rw, m_mux, m_wreg, m_wdata};
  endfunction

  task automatic model_clear();
    ma_v = 0; mb_v = 0;
    ma_reg = 0; mb_reg = 0;
    ma_data = 0; mb_data = 0;
    ma_ts = 0; mb_ts = 0;
    m_rw = 0; m_mux = 0; m_wreg = 0; m_wdata = 0;
`ifdef WB_ARB_RR_EN
    m_last = 1;
`endif
  endtask

  task automatic tick();
    logic ga, gb, ra, rb;
    @(posedge Clk);
    if (Reset) begin
      model_clear();
    end else begin
      mgrant(ga, gb);
      ra = !ma_v || ga;
      rb = !mb_v || gb;
      m_rw = ga || gb;
      if (ga) begin
        m_wreg = ma_reg; m_wdata = ma_data; m_mux = 0;
        ma_v = 0;
      end else if (gb) begin
        m_wreg = mb_reg; m_wdata = mb_data; m_mux = 1;
        mb_v = 0;
      end
`ifdef WB_ARB_RR_EN
      if (ga) m_last = 0;
      else if (gb) m_last = 1;
`endif
      if (A_Valid && ra && A_Reg != 0) begin
        ma_v = 1; ma_reg = A_Reg; ma_data = A_Data; ma_ts = cyc;
      end
      if (B_Valid && rb && B_Reg != 0) begin
        mb_v = 1; mb_reg = B_Reg; mb_data = B_Data; mb_ts = cyc;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic drive(input logic av, input logic [RW-1:0] ar,
                       input logic [DW-1:0] ad, input logic bv,
                       input logic [RW-1:0] br, input logic [DW-1:0] bd);
    A_Valid = av; A_Reg = ar; A_Data = ad;
    B_Valid = bv; B_Reg = br; B_Data = bd;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    Reset = 1;
    tick();
    Reset = 0;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0);
    Reset = 1;
    tick();
    tick();
    Reset = 0;
    checks++;
    if ({RegWrite, MuxSel, WriteReg, WriteData} !== '0) begin
      errors++;
      $display("FAIL reset_out: got %h want 0",
               {RegWrite, MuxSel, WriteReg, WriteData});
    end
    checks++;
    if ({A_Ready, B_Ready, Stall} !== 3'b110) begin
      errors++;
      $display("FAIL reset_ready: got %b want 110", {A_Ready, B_Ready, Stall});
    end
  endtask

  task automatic test_single_write();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive(1, 8, 32'h1234, 0, 0, 0);
      else drive(0, 0, 0, 0, 0, 0);
      checks++;
      if ({A_Ready, B_Ready, Stall} !== mready()) begin
        errors++;
        $display("FAIL single_ready c%0d: got %b want %b", i,
                 {A_Ready, B_Ready, Stall}, mready());
      end
      tick();
      checks++;
      if ({RegWrite, MuxSel, WriteReg, WriteData} !== mout()) begin
        errors++;
        $display("FAIL single_out c%0d: got %h want %h", i,
                 {RegWrite, MuxSel, WriteReg, WriteData}, mout());
      end
      checks++;
      if (i == 1) begin
        if ({RegWrite, MuxSel, WriteReg, WriteData} !== {1'b1, 1'b0, 5'd8, 32'h1234}) begin
          errors++;
          $display("FAIL single_write: got %b/%b/%0d/%h want 1/0/8/1234",
                   RegWrite, MuxSel, WriteReg, WriteData);
        end
      end else if (RegWrite !== 1'b0) begin
        errors++;
        $display("FAIL single_pulse c%0d: got RegWrite=%b want 0", i, RegWrite);
      end
    end
  endtask

  task automatic test_zero_reg();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive(1, 0, 32'hFFFF_FFFF, 0, 0, 0);
      else drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (A_Ready !== 1'b1) begin
        errors++;
        $display("FAIL zero_ready c%0d: got %b want 1", i, A_Ready);
      end
      tick();
      checks++;
      if (RegWrite !== 1'b0) begin
        errors++;
        $display("FAIL zero_nowrite c%0d: got %b want 0", i, RegWrite);
      end
    end
  endtask

  task automatic test_contention();
    int wn = 0;
    logic exp_mux;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 6) drive(1, 3, 32'hA + 32'(i) * 32'h100, 1, 5, 32'hB + 32'(i) * 32'h100);
      else drive(0, 0, 0, 0, 0, 0);
      checks++;
      if ({A_Ready, B_Ready, Stall} !== mready()) begin
        errors++;
        $display("FAIL cont_ready c%0d: got %b want %b", i,
                 {A_Ready, B_Ready, Stall}, mready());
      end
`ifndef WB_ARB_RR_EN
      if (i >= 1 && i < 6) begin
        checks++;
        if (B_Ready !== 1'b0) begin
          errors++;
          $display("FAIL cont_starve c%0d: got B_Ready=%b want 0", i, B_Ready);
        end
      end
`endif
      tick();
      checks++;
      if ({RegWrite, MuxSel, WriteReg, WriteData} !== mout()) begin
        errors++;
        $display("FAIL cont_out c%0d: got %h want %h", i,
                 {RegWrite, MuxSel, WriteReg, WriteData}, mout());
      end
      if (RegWrite === 1'b1 && wn < 4) begin
`ifdef WB_ARB_RR_EN
        exp_mux = wn[0];
`else
        exp_mux = 1'b0;
`endif
        checks++;
        if (MuxSel !== exp_mux) begin
          errors++;
          $display("FAIL cont_order w%0d: got MuxSel=%b want %b", wn, MuxSel, exp_mux);
        end
        wn++;
      end
    end
  endtask

  task automatic test_same_reg_order();
    int wn = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) drive(0, 0, 0, 1, 7, 32'h77);
      else if (i == 1) drive(1, 7, 32'h88, 0, 0, 0);
      else drive(0, 0, 0, 0, 0, 0);
      checks++;
      if ({A_Ready, B_Ready, Stall} !== mready()) begin
        errors++;
        $display("FAIL order_ready c%0d: got %b want %b", i,
                 {A_Ready, B_Ready, Stall}, mready());
      end
      tick();
      if (RegWrite === 1'b1) begin
        checks++;
        if (wn == 0 && {MuxSel, WriteReg, WriteData} !== {1'b1, 5'd7, 32'h77}) begin
          errors++;
          $display("FAIL order_first: got %b/%0d/%h want 1/7/77", MuxSel, WriteReg, WriteData);
        end else if (wn == 1 && {MuxSel, WriteReg, WriteData} !== {1'b0, 5'd7, 32'h88}) begin
          errors++;
          $display("FAIL order_second: got %b/%0d/%h want 0/7/88", MuxSel, WriteReg, WriteData);
        end else if (wn > 1) begin
          errors++;
          $display("FAIL order_extra: got write %h want none", WriteData);
        end
        wn++;
      end
    end
    checks++;
    if (wn != 2) begin
      errors++;
      $display("FAIL order_count: got %0d want 2", wn);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 9, 32'h99, 1, 10, 32'hAA);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    Reset = 1;
    tick();
    Reset = 0;
    checks++;
    if ({RegWrite, Stall, WriteReg, WriteData} !== '0) begin
      errors++;
      $display("FAIL rstmid_out: got %b/%b/%0d/%h want 0/0/0/0",
               RegWrite, Stall, WriteReg, WriteData);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (RegWrite !== 1'b0 || Stall !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_quiet c%0d: got RegWrite=%b Stall=%b want 0/0",
                 i, RegWrite, Stall);
      end
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] last_a;
    last_a = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: drive(1, 5, 32'h1, 1, 3, 32'h2);
        1: drive(1, 3, 32'h100, 0, 0, 0);
        2: drive(1, 3, 32'h200, 0, 0, 0);
        3: drive(1, 3, 32'h300, 0, 0, 0);
        default: drive(0, 0, 0, 0, 0, 0);
      endcase
      checks++;
      if (Stall !== (i == 2)) begin
        errors++;
        $display("FAIL stall_c%0d: got %b want %b", i, Stall, i == 2);
      end
      checks++;
      if ({A_Ready, B_Ready, Stall} !== mready()) begin
        errors++;
        $display("FAIL stall_ready c%0d: got %b want %b", i,
                 {A_Ready, B_Ready, Stall}, mready());
      end
      tick();
      checks++;
      if ({RegWrite, MuxSel, WriteReg, WriteData} !== mout()) begin
        errors++;
        $display("FAIL stall_out c%0d: got %h want %h", i,
                 {RegWrite, MuxSel, WriteReg, WriteData}, mout());
      end
      if (RegWrite === 1'b1 && MuxSel === 1'b0) last_a = WriteData;
    end
    checks++;
    if (last_a !== 32'h300) begin
      errors++;
      $display("FAIL stall_value: got %h want 300", last_a);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1) == 1, RW'($urandom_range(0, 3)), $urandom,
            $urandom_range(0, 1) == 1, RW'($urandom_range(0, 3)), $urandom);
      Reset = ($urandom_range(0, 63) == 0);
      checks++;
      if ({A_Ready, B_Ready, Stall} !== mready()) begin
        errors++;
        $display("FAIL rand_ready c%0d: got %b want %b", i,
                 {A_Ready, B_Ready, Stall}, mready());
      end
      tick();
      checks++;
      if ({RegWrite, MuxSel, WriteReg, WriteData} !== mout()) begin
        errors++;
        $display("FAIL rand_out c%0d: got %h want %h", i,
                 {RegWrite, MuxSel, WriteReg, WriteData}, mout());
      end
    end
    Reset = 0;
  endtask

  initial begin
    model_clear();
    Reset = 1;
    drive(0, 0, 0, 0, 0, 0);
    test_reset();
    test_single_write();
    test_zero_reg();
    test_contention();
    test_same_reg_order();
    test_reset_mid();
    test_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
